// File: rtl/id_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_pkg
// Constants and helpers shared by the ID/EX pipeline stage:
//   DEF_CTRL_W  default width of the opaque decoded control bundle
//   REG_W       register-index width
//   XLEN        datapath width
//   X0          index of the hard-wired zero register
//   bypass()    writeback-to-operand bypass selection
// -----------------------------------------------------------------------------
package id_ex_stage_pkg;

    localparam int DEF_CTRL_W = 8;
    localparam int REG_W      = 5;
    localparam int XLEN       = 32;

    localparam logic [REG_W-1:0] X0 = '0;

    // Writeback data wins over the regfile read when it targets the same
    // register in the same cycle. x0 is never bypassed, because a write to
    // x0 is architecturally discarded.
    function automatic logic [XLEN-1:0] bypass(
        input logic             wb_en,
        input logic [REG_W-1:0] wb_rd,
        input logic [XLEN-1:0]  wb_data,
        input logic [REG_W-1:0] rs,
        input logic [XLEN-1:0]  rf_data
    );
        if (wb_en && (wb_rd != X0) && (wb_rd == rs)) begin
            return wb_data;
        end
        return rf_data;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Combinational load-use hazard detection for the ID/EX stage.
// Ports:
//   i_rst          synchronous reset in progress (suppresses stall)
//   i_ex_flush     EX redirect this cycle (overrides the hazard)
//   i_ex_valid     EX register holds a real instruction
//   i_ex_mem_read  EX instruction is a load
//   i_ex_rd        EX destination register
//   i_id_valid     ID holds a real instruction
//   i_id_rs1/rs2   ID source registers
//   i_id_uses_rs1/rs2  ID instruction really reads that source
//   o_hz           raw load-use hazard
//   o_stall        hazard that actually stalls (not masked by flush/reset)
// -----------------------------------------------------------------------------
module hazard_unit
    import id_ex_stage_pkg::*;
(
    input  logic             i_rst,
    input  logic             i_ex_flush,
    input  logic             i_ex_valid,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs1,
    input  logic [REG_W-1:0] i_id_rs2,
    input  logic             i_id_uses_rs1,
    input  logic             i_id_uses_rs2,
    output logic             o_hz,
    output logic             o_stall
);

    logic w_rs1_match;
    logic w_rs2_match;

    assign w_rs1_match = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_match = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);

    // A load into x0 produces nothing to wait for.
    assign o_hz = i_ex_valid && i_ex_mem_read && (i_ex_rd != X0) && i_id_valid
                  && (w_rs1_match || w_rs2_match);

    // A redirect kills the ID instruction, so there is nothing left to hold.
    assign o_stall = o_hz && !i_ex_flush && !i_rst;

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register sitting directly downstream of the register file.
// Captures decoded ID fields and bypassed register operands, inserts a
// one-cycle bubble on a load-use hazard or an EX redirect, and keeps a
// saturating count of load-use stall cycles.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_*                     decoded instruction in ID
//   rf_data1/rf_data2        register file read data for id_rs1/id_rs2
//   wb_en/wb_rd/wb_data      same-cycle writeback (bypassed into operands)
//   ex_flush                 EX redirect: kill the ID instruction
//   stall                    hold PC and IF/ID this cycle (combinational)
//   ex_*                     registered EX-stage copies and operands
//   stall_cnt                saturating load-use stall counter
// -----------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_mem_read,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   rf_data1,
    input  logic [XLEN-1:0]   rf_data2,
    input  logic              wb_en,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_W-1:0]  ex_rs1,
    output logic [REG_W-1:0]  ex_rs2,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_mem_read,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_op1,
    output logic [XLEN-1:0]   ex_op2,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              r_ex_valid;
    logic [XLEN-1:0]   r_ex_pc;
    logic [XLEN-1:0]   r_ex_imm;
    logic [REG_W-1:0]  r_ex_rs1;
    logic [REG_W-1:0]  r_ex_rs2;
    logic [REG_W-1:0]  r_ex_rd;
    logic              r_ex_mem_read;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [XLEN-1:0]   r_ex_op1;
    logic [XLEN-1:0]   r_ex_op2;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_hz;
    logic              w_stall;
    logic [XLEN-1:0]   w_op1;
    logic [XLEN-1:0]   w_op2;

    hazard_unit u_hazard_unit (
        .i_rst         (rst),
        .i_ex_flush    (ex_flush),
        .i_ex_valid    (r_ex_valid),
        .i_ex_mem_read (r_ex_mem_read),
        .i_ex_rd       (r_ex_rd),
        .i_id_valid    (id_valid),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_uses_rs1 (id_uses_rs1),
        .i_id_uses_rs2 (id_uses_rs2),
        .o_hz          (w_hz),
        .o_stall       (w_stall)
    );

    // NOTE: every variable assigned in always_comb gets its default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_op1 = rf_data1;
        w_op2 = rf_data2;
        w_op1 = bypass(wb_en, wb_rd, wb_data, id_rs1, rf_data1);
        w_op2 = bypass(wb_en, wb_rd, wb_data, id_rs2, rf_data2);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid    <= 1'b0;
            r_ex_pc       <= '0;
            r_ex_imm      <= '0;
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_rd       <= '0;
            r_ex_mem_read <= 1'b0;
            r_ex_ctrl     <= '0;
            r_ex_op1      <= '0;
            r_ex_op2      <= '0;
            r_stall_cnt   <= '0;
        end else if (ex_flush || w_hz) begin
            // Bubble: only the fields EX acts on are cleared; data fields
            // are don't-care while ex_valid is low and are simply held.
            r_ex_valid    <= 1'b0;
            r_ex_mem_read <= 1'b0;
            r_ex_ctrl     <= '0;
            // A flush wins over the hazard, so only true stalls are counted.
            if (!ex_flush && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end else begin
            r_ex_valid    <= id_valid;
            r_ex_pc       <= id_pc;
            r_ex_imm      <= id_imm;
            r_ex_rs1      <= id_rs1;
            r_ex_rs2      <= id_rs2;
            r_ex_rd       <= id_rd;
            r_ex_mem_read <= id_mem_read;
            r_ex_ctrl     <= id_ctrl;
            r_ex_op1      <= w_op1;
            r_ex_op2      <= w_op2;
        end
    end

    assign stall       = w_stall;
    assign ex_valid    = r_ex_valid;
    assign ex_pc       = r_ex_pc;
    assign ex_imm      = r_ex_imm;
    assign ex_rs1      = r_ex_rs1;
    assign ex_rs2      = r_ex_rs2;
    assign ex_rd       = r_ex_rd;
    assign ex_mem_read = r_ex_mem_read;
    assign ex_ctrl     = r_ex_ctrl;
    assign ex_op1      = r_ex_op1;
    assign ex_op2      = r_ex_op2;
    assign stall_cnt   = r_stall_cnt;

endmodule
